// File: rtl/ififo.sv
// Input-side elastic FIFO: SLOTS-entry circular buffer feeding a registered output stage.
// Optional build macro IFIFO_OCCUPANCY_EN adds an occupancy output (count + out_valid).
module ififo #(
    parameter int SLOTS      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef IFIFO_OCCUPANCY_EN
    ,
    output logic [$clog2(SLOTS+2)-1:0] occupancy
`endif
);

    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    logic [DATA_WIDTH-1:0] mem [SLOTS];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    logic in_xfer;
    logic out_load;
    logic pop;
    logic bypass;
    logic push;

    // Pointers wrap by explicit compare so SLOTS need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Ready is derived from stored occupancy only, keeping the ready path cut.
    assign ins_ready = (count != FULL_CNT);
    assign in_xfer   = ins_valid & ins_ready;
    assign out_load  = ~out_valid | outs_ready;
    assign pop       = out_load & (count != '0);
    assign bypass    = out_load & (count == '0) & in_xfer;
    assign push      = in_xfer & ~bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Older stored tokens always win the output register; bypass only when storage is empty.
            if (out_load) begin
                if (pop) begin
                    out_data  <= mem[head];
                    out_valid <= 1'b1;
                end else if (in_xfer) begin
                    out_data  <= ins;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= ins;
        end
    end

    assign outs       = out_data;
    assign outs_valid = out_valid;

`ifdef IFIFO_OCCUPANCY_EN
    localparam int OCC_W = $clog2(SLOTS + 2);
    assign occupancy = OCC_W'(count) + OCC_W'(out_valid);
`endif

endmodule
